// File: rtl/exe_mdu_sequencer.sv
// Iterative multiply/divide sequencer beside the EXE-stage ALU; results land in HI/LO.
// Build option: MDU_EARLY_OUT_EN ends a multiply early once the remaining multiplier bits are zero.
module exe_mdu_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   input  logic             flush,
   output logic             freeze,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state | meaning
   // IDLE  | waiting for a command
   // BUSY  | one multiply/divide iteration per cycle
   // DONE  | hi/lo hold the new result, done pulses
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   shreg;
   logic               is_div, neg_res, neg_rem;

   logic               accept, div_zero, last_iter, ge;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [2*WIDTH-1:0] acc_step, prod_fix;
   logic [WIDTH:0]     rem_sh, rem_sub;
   logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;

   assign accept   = (state == S_IDLE) && start && !flush;
   assign div_zero = op[1] && (val2 == '0);
   assign mag1     = (op[0] && val1[WIDTH-1]) ? -val1 : val1;
   assign mag2     = (op[0] && val2[WIDTH-1]) ? -val2 : val2;

   // Multiply: acc accumulates the left-shifting multiplicand for each set multiplier bit.
   assign acc_step = shreg[0] ? (acc + mcand) : acc;
   assign prod_fix = neg_res ? -acc_step : acc_step;

   // Restoring divide: partial remainder in acc[WIDTH-1:0], divisor in mcand[WIDTH-1:0].
   assign rem_sh   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
   assign rem_sub  = rem_sh - {1'b0, mcand[WIDTH-1:0]};
   assign ge       = !rem_sub[WIDTH];
   assign rem_step = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_step = {shreg[WIDTH-2:0], ge};
   assign quo_fix  = neg_res ? -quo_step : quo_step;
   assign rem_fix  = neg_rem ? -rem_step : rem_step;

`ifdef MDU_EARLY_OUT_EN
   assign last_iter = (count == CNT_W'(1)) || (!is_div && (shreg[WIDTH-1:1] == '0));
`else
   assign last_iter = (count == CNT_W'(1));
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = div_zero ? S_DONE : S_BUSY;
         S_BUSY:  if (flush) state_nxt = S_IDLE;
                  else if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != S_IDLE);
      done   = (state == S_DONE);
      freeze = !rst && (accept || (state == S_BUSY));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         shreg   <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               count   <= CNT_W'(WIDTH);
               is_div  <= op[1];
               neg_res <= op[0] && (val1[WIDTH-1] ^ val2[WIDTH-1]);
               neg_rem <= op[0] && val1[WIDTH-1];
               acc     <= '0;
               if (op[1]) begin
                  mcand <= {{WIDTH{1'b0}}, mag2};
                  shreg <= mag1;
               end else begin
                  mcand <= {{WIDTH{1'b0}}, mag1};
                  shreg <= mag2;
               end
               if (div_zero) begin
                  hi <= val1;
                  lo <= '1;
               end
            end
            S_BUSY: if (!flush) begin
               count <= count - CNT_W'(1);
               if (is_div) begin
                  acc   <= {{WIDTH{1'b0}}, rem_step};
                  shreg <= quo_step;
               end else begin
                  acc   <= acc_step;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
               end
               // Result is registered on the way into DONE so it is visible while done pulses.
               if (last_iter) begin
                  if (is_div) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     {hi, lo} <= prod_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_mdu_sequencer.sv
// Scoreboard bench for exe_mdu_sequencer: driver pushes expected results, a monitor pops on done.
module tb_exe_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] val1, val2;
   logic        freeze, busy, done;
   logic [31:0] hi, lo;

   exe_mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .val1(val1), .val2(val2),
      .flush(flush), .freeze(freeze), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          at;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference model straight from the arithmetic definitions.
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int lat);
      longint      sa, sbv, q, r;
      logic [63:0] p;
      logic [31:0] m;
      int          msb;
      sa  = $signed(a);
      sbv = $signed(b);
      lat = 33;
      case (o)
         2'b00: p = {32'h0, a} * {32'h0, b};
         2'b01: p = sa * sbv;
         2'b10: if (b != 0) p = {a % b, a / b};
         default: if (b != 0) begin
            q = sa / sbv;
            r = sa % sbv;
            p = {r[31:0], q[31:0]};
         end
      endcase
      if (o[1] && b == 0) begin
         p   = {a, 32'hFFFF_FFFF};
         lat = 1;
      end
`ifdef MDU_EARLY_OUT_EN
      if (!o[1]) begin
         m   = (o[0] && b[31]) ? -b : b;
         msb = 0;
         for (int i = 0; i < 32; i++) if (m[i]) msb = i;
         lat = msb + 2;
      end
`endif
      h = p[63:32];
      l = p[31:0];
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done act=1 exp=0 cyc=%0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.at));
            chk("hi", {32'h0, hi}, {32'h0, e.hi});
            chk("lo", {32'h0, lo}, {32'h0, e.lo});
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] h, l;
      int          lat, t;
      @(negedge clk);
      start = 1'b1; flush = 1'b0; op = o; val1 = a; val2 = b;
      model(o, a, b, h, l, lat);
      t = cyc;
      sb.push_back('{h, l, t + lat});
      m_hi = h;
      m_lo = l;
      #1 chk("freeze_accept", 64'(freeze), 64'd1);
      for (int c = t + 1; c <= t + lat; c++) begin
         @(negedge clk);
         // Commands during the operation must be ignored; flush only in the DONE cycle.
         start = 1'($urandom_range(0, 1));
         op    = 2'($urandom_range(0, 3));
         val1  = $urandom;
         val2  = $urandom;
         flush = (cyc == t + lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         #1 chk("freeze_run", 64'(freeze), 64'(cyc < t + lat));
      end
   endtask

   task automatic abort(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int k, input bit use_rst);
      @(negedge clk);
      start = 1'b1; flush = 1'b0; op = o; val1 = a; val2 = b;
      #1 chk("freeze_accept_ab", 64'(freeze), 64'd1);
      @(negedge clk);
      start = 1'b0;
      repeat (k - 1) @(negedge clk);
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      #1 chk("freeze_abort", 64'(freeze), use_rst ? 64'd0 : 64'd1);
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      if (use_rst) begin
         m_hi = '0;
         m_lo = '0;
      end
      #1;
      chk("busy_after_abort", 64'(busy), 64'd0);
      chk("done_after_abort", 64'(done), 64'd0);
      chk("hi_after_abort", {32'h0, hi}, {32'h0, m_hi});
      chk("lo_after_abort", {32'h0, lo}, {32'h0, m_lo});
      repeat (40) @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b00; val1 = 32'h5; val2 = 32'h7;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_hi", {32'h0, hi}, 64'd0);
      chk("rst_lo", {32'h0, lo}, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_freeze", 64'(freeze), 64'd0);
      rst = 1'b0;
      start = 1'b0;

      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b01, 32'hFFFF_FFFD, 32'd7);
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      issue(2'b10, 32'd100, 32'd0);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'b11, 32'hFFFF_FFF9, 32'd0);

      // flush mid-multiply, then a divide after it
      abort(2'b00, 32'd6, 32'h8000_0007, 10, 1'b0);
      issue(2'b10, 32'd43, 32'd5);

      // start together with flush in IDLE is not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b10; val1 = 32'd9; val2 = 32'd3;
      #1 chk("freeze_flush_idle", 64'(freeze), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 chk("busy_flush_idle", 64'(busy), 64'd0);

      abort(2'b11, 32'h1234_5678, 32'h0000_0123, 20, 1'b1);

      issue(2'b00, 32'h1234_5678, 32'd5);
      issue(2'b00, 32'hDEAD_BEEF, 32'd0);
      issue(2'b01, 32'h8000_0000, 32'h8000_0000);

      for (int n = 0; n < 40; n++)
         issue(2'($urandom_range(0, 3)), pick(), pick());

      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      repeat (4) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_mdu_sequencer.md
Name: exe_mdu_sequencer

Overview:
Iterative multiply/divide sequencer beside the EXE stage ALU.
- Accepts a multi-cycle MULT/DIV command from ID/EXE.
- Freezes the upstream pipeline while it iterates.
- Writes 64-bit results into internal HI/LO registers.
- Sits in parallel with the single-cycle ALU; the pipeline controller ORs `freeze` into its stall chain.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  command valid from EXE; sampled in IDLE only
- op  input  2  00 MULTU, 01 MULT signed, 10 DIVU, 11 DIV signed
- val1  input  WIDTH  multiplicand / dividend
- val2  input  WIDTH  multiplier / divisor
- flush  input  1  abort in-flight operation (branch taken / exception)
- freeze  output  1  stall request to PC, IF/ID and ID/EXE registers
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse: HI/LO updated this cycle
- hi  output  WIDTH  product high word / remainder
- lo  output  WIDTH  product low word / quotient

Behaviour:
- Clock and reset: one clock (`clk`); synchronous active-high reset (`rst`).
- Reset values: state IDLE, count 0, hi 0, lo 0, done 0, busy 0. `freeze` is forced 0 while `rst` is high.
- States:
  - IDLE: `start` & ~`flush` -> latch operands, op and operand signs; go to BUSY with count = WIDTH.
  - BUSY: one iteration per cycle; count decrements; count reaches 1 -> DONE.
  - DONE: apply sign correction, write hi/lo, pulse `done`; go to IDLE next cycle.
- Latency: start accepted at cycle T; `done` = 1 at T+WIDTH+1 (T+33 for WIDTH=32). hi/lo are valid from that same cycle.
- Freeze: `freeze` = (IDLE & `start` & ~`flush`) | BUSY. It is combinational on `start` so the issuing instruction holds in EXE. It is 0 in DONE, so the pipeline advances the cycle `done` pulses.
- Multiply:
  - Shift-add on operand magnitudes; 2*WIDTH-bit accumulator.
  - Signed (op=01): negate the 2*WIDTH-bit product when the operand signs differ.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Signed (op=11): quotient negated when signs differ; remainder takes the dividend's sign.
  - hi = remainder, lo = quotient.
- Divide by zero (val2 == 0, op 1x): skip BUSY; IDLE -> DONE next cycle; lo = all ones, hi = val1 unmodified. `freeze` is asserted only in the accept cycle.
- Signed overflow (DIV, val1 = 0x80000000, val2 = 0xFFFFFFFF): falls out of the magnitude algorithm as lo = 0x80000000, hi = 0. No special case.
- `start` while BUSY or DONE: ignored; no queueing.
- `flush`:
  - In BUSY: return to IDLE next cycle; hi/lo unchanged; no `done`.
  - In DONE: ignored; the result commits.
  - In IDLE with `start`: command not accepted.
- `rst` mid-operation: immediate return to reset values; no `done`.
- hi/lo hold their value except in DONE and on reset.

Optional Feature:
Macro MDU_EARLY_OUT_EN.
- Defined: in a multiply, when the remaining unshifted multiplier bits are all zero, BUSY exits to DONE the next cycle. Latency becomes (index of highest set bit of |val2|) + 2 cycles; multiply by 0 takes 2 cycles (IDLE -> DONE via one BUSY cycle). `freeze` tracks the shortened BUSY. Divide latency is unchanged.
- Undefined: fixed WIDTH+1 latency for every non-zero-divisor operation.

Test Plan:
1. MULTU val1=0xFFFFFFFF, val2=0xFFFFFFFF -> `done` at T+33; hi=0xFFFFFFFE, lo=0x00000001; `freeze` high T..T+32, low at T+33.
2. MULT val1=0xFFFFFFFD (-3), val2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV val1=-7, val2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
3. DIVU val1=100, val2=0 -> `done` at T+1; lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MULTU 6*7 with `flush` at T+10 -> IDLE at T+11, no `done`, hi/lo keep prior values; then DIVU 43/5 -> lo=8, hi=3 at its own T'+33.
5. `start` re-asserted at T+5 with different operands during BUSY -> ignored; first result returned unchanged. `rst` at T+20 -> hi=lo=0, `busy`=0, no `done`.
6. With MDU_EARLY_OUT_EN: MULTU 0x12345678 * 5 -> `done` at T+4, lo=0x5B05B058, hi=0; MULTU x*0 -> `done` at T+2, hi=lo=0.
